alu_iter: RTL and testbench
===========================

// Module: alu_iter
// PURPOSE
//  Parametrised, handshaked successor to the combinational 8-bit ALU. Accepts one operation per
//  transaction on a valid/ready input port and returns a registered result and flags on a
//  valid/ready output port. Logic and arithmetic ops take 1 cycle. Shifts and rotates run
//  iteratively at 1 bit per cycle, so area does not grow with WIDTH. Sits between decode and
//  writeback, and stalls the core through InReady.
// PARAMETERS
//  WIDTH      8   operand/result width in bits (>=2)
//  FAST_SHIFT 0   1: shifts complete in 1 cycle like other ops; 0: iterative 1 bit/cycle
//  CNT_W (localparam) = $clog2(WIDTH+1), width of the shift counter
// PORTS
//  Clk       in   1      clock, rising edge
//  Reset_n   in   1      asynchronous, active-low reset
//  InValid   in   1      operands/OP valid
//  InReady   out  1      block can accept an operation this cycle
//  InputA    in   WIDTH  operand A (value shifted for shift ops)
//  InputB    in   WIDTH  operand B (shift amount for shift ops, unsigned)
//  OP        in   4      opcode, type op_mne
//  OutValid  out  1      Out and flags valid
//  OutReady  in   1      consumer accepts result
//  Out       out  WIDTH  result
//  Zero      out  1      Out == 0
//  Parity    out  1      ^Out (1 = odd number of ones)
//  Carry     out  1      ADD carry-out; BNE borrow (A<B unsigned); shift/rotate: last bit moved out, 0 if amount 0; else 0
//  Illegal   out  1      OP not a defined op_mne code
// BEHAVIOUR
//  Reset: state IDLE; InReady=1 while Reset_n high in IDLE; OutValid, Out, Zero, Parity, Carry, Illegal all 0.
//   Reset takes effect asynchronously in any state and discards any op in flight.
//  Ops: ADD A+B, AND, OR0, XOR, BNE A-B (subtract), SLL, SRL, SRA (sign fill), ROL (rotate left).
//   All ops are mod 2^WIDTH.
//  Shift amount n = min(InputB, WIDTH) for SLL/SRL/SRA. ROL uses n = InputB mod WIDTH.
//  FSM: IDLE -> (accept, non-shift or n==0 or FAST_SHIFT) -> DONE; IDLE -> (accept, iterative shift, n>0) -> SHIFT;
//   SHIFT: 1 bit per cycle, counter decrements, -> DONE on the cycle the counter reaches 0;
//   DONE: OutValid=1; -> IDLE on OutReady unless a new op is accepted in the same cycle.
//  Accept = InValid & InReady. InReady = (state==IDLE) | (state==DONE & OutReady).
//   InReady=0 in SHIFT.
//  Latency from accept edge to OutValid: 1 cycle for non-shift ops; 1+n cycles for iterative shifts.
//  DONE with OutReady=0: Out and all flags held stable; OutValid stays 1; no new accept.
//  DONE with OutReady=1 and InValid=1 in the same cycle: result retires and the new op is captured.
//   Zero bubble for a 1-cycle op.
//  Operands and OP are captured at accept. Later changes on the inputs have no effect.
//  Illegal OP: completes with 1-cycle latency; Out=0, Zero=1, Parity=0, Carry=0, Illegal=1.
//  Flags are computed from the final registered Out and are valid only while OutValid=1.
// STRUCTURE
//  Definitions package:
//   - extend op_mne with SRA and ROL on two unused 4-bit codes; existing encodings unchanged
//   - add typedef alu_state_e {IDLE, SHIFT, DONE}
//  Sub-module alu_shift_step (combinational): one-bit SLL/SRL/SRA/ROL of a WIDTH value.
//   Outputs the shifted value and the bit shifted out. Reused by the iterative path.
//   With FAST_SHIFT=1 the fast path uses the native shift operators instead.
// TESTING (WIDTH=8, FAST_SHIFT=0 unless stated)
//  1 ADD A=FF B=01 -> Out=00 Zero=1 Carry=1 Parity=0; OutValid exactly 1 cycle after accept.
//  2 BNE A=06 B=06 -> Out=00 Zero=1 Carry=0; A=03 B=05 -> Out=FE Carry=1 Parity=1.
//  3 SLL A=03 B=3 -> Out=18, OutValid 4 cycles after accept, InReady=0 for the 3 SHIFT cycles.
//    SRA A=80 B=2 -> Out=E0. ROL A=81 B=1 -> Out=03 Carry=1.
//    Repeat with FAST_SHIFT=1: same values, latency 1.
//  4 SRL A=F0 B=20 -> n clamps to 8: Out=00 Zero=1 Carry=1, latency 9. OP=4'hF -> Illegal=1, Out=00.
//  5 OutReady=0 for 5 cycles in DONE -> Out and flags stable, InReady=0.
//    Then OutReady=1 with InValid=1 (AND A=0F B=3C) -> new op accepted that cycle, next Out=0C.
//  6 Reset_n low mid-SHIFT (SLL B=7, cycle 3) -> all outputs 0 immediately.
//    After release, InReady=1 and no stale result is ever presented.

Source files
------------

// File: rtl/alu_iter_pkg.sv
// Shared opcode and state definitions for the handshaked iterative ALU.
package alu_iter_pkg;

  typedef enum logic [3:0] {
    ADD = 4'h0,
    AND = 4'h1,
    OR0 = 4'h2,
    XOR = 4'h3,
    BNE = 4'h4,
    SLL = 4'h5,
    SRL = 4'h6,
    SRA = 4'h7,
    ROL = 4'h8
  } op_mne;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_e;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= 4'h8;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    return (op == SLL) || (op == SRL) || (op == SRA) || (op == ROL);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift/rotate of a WIDTH-bit value; also reports the bit that left the word.
module alu_shift_step
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_mne              op,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   dout,
  output logic               bit_out
);

  always_comb begin
    dout    = din;
    bit_out = 1'b0;
    case (op)
      SLL: begin
        dout    = {din[WIDTH-2:0], 1'b0};
        bit_out = din[WIDTH-1];
      end
      SRL: begin
        dout    = {1'b0, din[WIDTH-1:1]};
        bit_out = din[0];
      end
      SRA: begin
        dout    = {din[WIDTH-1], din[WIDTH-1:1]};
        bit_out = din[0];
      end
      ROL: begin
        dout    = {din[WIDTH-2:0], din[WIDTH-1]};
        bit_out = din[WIDTH-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked ALU: 1-cycle logic/arith ops, shifts either single-cycle (FAST_SHIFT)
// or iterated one bit per cycle through alu_shift_step.
module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InputA,
  input  logic [WIDTH-1:0] InputB,
  input  logic [3:0]       OP,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Out,
  output logic             Zero,
  output logic             Parity,
  output logic             Carry,
  output logic             Illegal
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  alu_state_e       state_reg;
  op_mne            op_reg;
  logic [WIDTH-1:0] work_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] out_reg;
  logic             zero_reg, parity_reg, carry_reg, illegal_reg;

  logic             accept, go_iter, load_result;
  logic [WIDTH-1:0] rol_mod;
  logic [CNT_W-1:0] amount;
  logic [WIDTH:0]   sum_w, dif_w, sll_w, srl_w, sra_w;
  logic [WIDTH-1:0] rol_v;
  logic [WIDTH-1:0] imm_val, step_val, fin_val;
  logic             imm_carry, step_bit, fin_carry, fin_illegal;

  assign InReady = Reset_n & ((state_reg == IDLE) | ((state_reg == DONE) & OutReady));
  assign accept  = InValid & InReady;

  // Linear shifts clamp at WIDTH; rotate wraps modulo WIDTH.
  always_comb begin
    rol_mod = InputB % WIDTH_V;
    if (OP == ROL)             amount = rol_mod[CNT_W-1:0];
    else if (InputB > WIDTH_V) amount = WIDTH_C;
    else                       amount = InputB[CNT_W-1:0];
  end

  assign go_iter = !FAST_SHIFT && is_shift(OP) && (amount != '0);

  always_comb begin
    sum_w     = {1'b0, InputA} + {1'b0, InputB};
    dif_w     = {1'b0, InputA} - {1'b0, InputB};
    sll_w     = {1'b0, InputA} << amount;
    srl_w     = {InputA, 1'b0} >> amount;
    sra_w     = $unsigned($signed({InputA, 1'b0}) >>> amount);
    rol_v     = (InputA << amount) | (InputA >> (WIDTH_C - amount));
    imm_val   = '0;
    imm_carry = 1'b0;
    case (OP)
      ADD: {imm_carry, imm_val} = sum_w;
      AND: imm_val = InputA & InputB;
      OR0: imm_val = InputA | InputB;
      XOR: imm_val = InputA ^ InputB;
      BNE: {imm_carry, imm_val} = dif_w;
      SLL: {imm_carry, imm_val} = sll_w;
      SRL: {imm_val, imm_carry} = srl_w;
      SRA: {imm_val, imm_carry} = sra_w;
      ROL: begin
        imm_val   = rol_v;
        imm_carry = (amount != '0) & rol_v[0];
      end
      default: ;
    endcase
    // In iterative mode only a zero-amount shift completes here: result is A untouched.
    if (!FAST_SHIFT && is_shift(OP)) begin
      imm_val   = InputA;
      imm_carry = 1'b0;
    end
  end

  alu_shift_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_reg),
    .din     (work_reg),
    .dout    (step_val),
    .bit_out (step_bit)
  );

  always_comb begin
    if (state_reg == SHIFT) begin
      fin_val     = step_val;
      fin_carry   = step_bit;
      fin_illegal = 1'b0;
      load_result = (cnt_reg == CNT_W'(1));
    end else begin
      fin_val     = imm_val;
      fin_carry   = imm_carry;
      fin_illegal = !is_legal(OP);
      load_result = accept & !go_iter;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      op_reg      <= ADD;
      work_reg    <= '0;
      cnt_reg     <= '0;
      out_reg     <= '0;
      zero_reg    <= 1'b0;
      parity_reg  <= 1'b0;
      carry_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (go_iter) begin
              state_reg <= SHIFT;
              work_reg  <= InputA;
              cnt_reg   <= amount;
              op_reg    <= op_mne'(OP);
            end else begin
              state_reg <= DONE;
            end
          end else if (state_reg == DONE && OutReady) begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          work_reg <= step_val;
          cnt_reg  <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_reg <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
      if (load_result) begin
        out_reg     <= fin_val;
        zero_reg    <= ~|fin_val;
        parity_reg  <= ^fin_val;
        carry_reg   <= fin_carry;
        illegal_reg <= fin_illegal;
      end
    end
  end

  assign OutValid = (state_reg == DONE);
  assign Out      = out_reg;
  assign Zero     = zero_reg;
  assign Parity   = parity_reg;
  assign Carry    = carry_reg;
  assign Illegal  = illegal_reg;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench: iterative (s_*) and fast-shift (f_*) ALUs driven by the same stimulus.
module tb_alu_iter;
  import alu_iter_pkg::*;

  logic       clk, rst_n, in_valid, out_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] op;

  logic       s_in_ready, s_out_valid, s_zero, s_parity, s_carry, s_illegal;
  logic [7:0] s_out;
  logic       f_in_ready, f_out_valid, f_zero, f_parity, f_carry, f_illegal;
  logic [7:0] f_out;

  int checks   = 0;
  int failures = 0;

  alu_iter #(.WIDTH(8), .FAST_SHIFT(1'b0)) u_slow (
    .Clk(clk), .Reset_n(rst_n), .InValid(in_valid), .InReady(s_in_ready),
    .InputA(in_a), .InputB(in_b), .OP(op), .OutValid(s_out_valid), .OutReady(out_ready),
    .Out(s_out), .Zero(s_zero), .Parity(s_parity), .Carry(s_carry), .Illegal(s_illegal)
  );

  alu_iter #(.WIDTH(8), .FAST_SHIFT(1'b1)) u_fast (
    .Clk(clk), .Reset_n(rst_n), .InValid(in_valid), .InReady(f_in_ready),
    .InputA(in_a), .InputB(in_b), .OP(op), .OutValid(f_out_valid), .OutReady(out_ready),
    .Out(f_out), .Zero(f_zero), .Parity(f_parity), .Carry(f_carry), .Illegal(f_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Issues one op, then checks latency, busy cycles, result and flags on both instances.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input int exp_lat, input logic [7:0] exp_out,
                        input logic ez, input logic ep, input logic ec, input logic ei);
    int lat;
    int busy;
    chk({tag, ".in_ready"}, {s_in_ready, f_in_ready}, 2'b11);
    in_valid = 1'b1; op = o; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'h1; in_a = ~a; in_b = 8'h55;
    chk({tag, ".fast_valid"}, f_out_valid, 1'b1);
    chk({tag, ".fast_out"}, f_out, exp_out);
    chk({tag, ".fast_flags"}, {f_zero, f_parity, f_carry, f_illegal}, {ez, ep, ec, ei});
    lat = 1; busy = 0;
    while (!s_out_valid && lat < 20) begin
      if (!s_in_ready) busy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".busy_cycles"}, busy, exp_lat - 1);
    chk({tag, ".out"}, s_out, exp_out);
    chk({tag, ".flags"}, {s_zero, s_parity, s_carry, s_illegal}, {ez, ep, ec, ei});
    @(posedge clk); #1;
    chk({tag, ".retired"}, {s_out_valid, f_out_valid}, 2'b00);
    $display("txn %s op=%0h a=%02h b=%02h out=%02h lat=%0d", tag, o, a, b, s_out, lat);
  endtask

  initial begin
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 8'h00; in_b = 8'h00; op = 4'h0;
    #12;
    chk("reset.outputs", {s_out_valid, s_out, s_zero, s_parity, s_carry, s_illegal, s_in_ready},
        14'h0);
    chk("reset.fast", {f_out_valid, f_out, f_in_ready}, 10'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("reset.release_ready", {s_in_ready, f_in_ready}, 2'b11);
    @(posedge clk); #1;

    //     tag            op   A      B      lat out    Z     P     C     I
    run_op("add_ovf",     ADD, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("bne_eq",      BNE, 8'h06, 8'h06, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("bne_borrow",  BNE, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b1, 1'b1, 1'b0);
    run_op("or",          OR0, 8'hA0, 8'h0A, 1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("xor",         XOR, 8'hFF, 8'h0F, 1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sll3",        SLL, 8'h03, 8'h03, 4, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sra2",        SRA, 8'h80, 8'h02, 3, 8'hE0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("rol1",        ROL, 8'h81, 8'h01, 2, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("rol9",        ROL, 8'h81, 8'h09, 2, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("rol8",        ROL, 8'h81, 8'h08, 1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sll0",        SLL, 8'h5A, 8'h00, 1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("srl_clamp",   SRL, 8'hF0, 8'h20, 9, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("illegal",     4'hF, 8'h12, 8'h34, 1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    in_valid = 1'b1; op = ADD; in_a = 8'h7F; in_b = 8'h01;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("stall.hold", {s_out_valid, s_in_ready, s_out, s_zero, s_parity, s_carry, s_illegal},
          {1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0});
      @(posedge clk); #1;
    end
    $display("txn stall add a=7f b=01 out=%02h held 5 cycles", s_out);
    out_ready = 1'b1;
    in_valid = 1'b1; op = AND; in_a = 8'h0F; in_b = 8'h3C;
    #1;
    chk("stall.ready_on_retire", s_in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.and", {s_out_valid, s_out, f_out_valid, f_out}, {1'b1, 8'h0C, 1'b1, 8'h0C});
    $display("txn b2b and a=0f b=3c out=%02h", s_out);
    @(posedge clk); #1;
    chk("b2b.retired", s_out_valid, 1'b0);

    // Reset in the middle of a 7-bit shift.
    in_valid = 1'b1; op = SLL; in_a = 8'h01; in_b = 8'h07;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.outputs", {s_out_valid, s_out, s_zero, s_parity, s_carry, s_illegal, s_in_ready},
        14'h0);
    chk("midreset.fast", {f_out_valid, f_out, f_in_ready}, 10'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midreset.ready", {s_in_ready, f_in_ready}, 2'b11);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (s_out_valid || f_out_valid) stale++;
    end
    chk("midreset.no_stale", stale, 0);
    $display("txn reset_mid_shift stale_cycles=%0d", stale);
    run_op("post_reset",  ADD, 8'h01, 8'h02, 1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
